// File: rtl/seq_muldiv_pkg.sv
// seq_muldiv_pkg: funct3 codes, FSM states and per-op decode shared by the multiply/divide unit.
package seq_muldiv_pkg;
  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic [1:0] {SEL_LO = 2'd0, SEL_HI = 2'd1, SEL_QUO = 2'd2, SEL_REM = 2'd3} sel_e;
  typedef struct packed {
    logic a_sgn;
    logic b_sgn;
    sel_e sel;
  } op_attr_t;
  function automatic op_attr_t op_attr(input logic [2:0] op);
    op_attr_t r;
    r = '{a_sgn: 1'b0, b_sgn: 1'b0, sel: SEL_LO};
    case (op)
      MULDIV_OP_MUL:    r = '{a_sgn: 1'b0, b_sgn: 1'b0, sel: SEL_LO};
      MULDIV_OP_MULH:   r = '{a_sgn: 1'b1, b_sgn: 1'b1, sel: SEL_HI};
      MULDIV_OP_MULHSU: r = '{a_sgn: 1'b1, b_sgn: 1'b0, sel: SEL_HI};
      MULDIV_OP_MULHU:  r = '{a_sgn: 1'b0, b_sgn: 1'b0, sel: SEL_HI};
      MULDIV_OP_DIV:    r = '{a_sgn: 1'b1, b_sgn: 1'b1, sel: SEL_QUO};
      MULDIV_OP_DIVU:   r = '{a_sgn: 1'b0, b_sgn: 1'b0, sel: SEL_QUO};
      MULDIV_OP_REM:    r = '{a_sgn: 1'b1, b_sgn: 1'b1, sel: SEL_REM};
      MULDIV_OP_REMU:   r = '{a_sgn: 1'b0, b_sgn: 1'b0, sel: SEL_REM};
      default:          r = '{a_sgn: 1'b0, b_sgn: 1'b0, sel: SEL_LO};
    endcase
    return r;
  endfunction
endpackage

// File: rtl/seq_muldiv_step.sv
// seq_muldiv_step: one iteration of shift-add multiply or restoring divide on a 2*XLEN accumulator.
module seq_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opd,
  output logic [2*XLEN-1:0] acc_nxt
);
  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
    acc_nxt = !is_div ? {sum, acc[XLEN-1:1]}
            : diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end
endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative RV32M/RV64M multiply/divide unit with tagged valid/ready handshakes and flush.
// Define SEQ_MULDIV_EARLY_OUT_EN to skip iteration for divide-by-zero, signed overflow and zero-operand multiply.
module seq_muldiv
  import seq_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
`ifdef SEQ_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int CW = $clog2(XLEN + 1);
  state_e state;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0] opd, a_mag, b_mag, spec_val, spec_val_n, quo, rem, res_fix;
  logic [TAG_W-1:0] tag;
  op_attr_t attr, attr_n;
  logic a_neg, b_neg, neg, neg_n, div0, ovf, mul0, spec, spec_n, rem_n;
  always_comb begin
    attr_n = op_attr(op_i);
    rem_n = attr_n.sel == SEL_REM;
    a_neg = attr_n.a_sgn & a_i[XLEN-1];
    b_neg = attr_n.b_sgn & b_i[XLEN-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    neg_n = rem_n ? a_neg : a_neg ^ b_neg;
    div0 = op_i[2] && b_i == '0;
    ovf = op_i[2] && attr_n.a_sgn && a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1;
    mul0 = EARLY && !op_i[2] && (a_i == '0 || b_i == '0);
    spec_n = div0 | ovf | mul0;
    spec_val_n = div0 ? (rem_n ? a_i : '1) : (ovf && !rem_n) ? a_i : '0;
  end
  seq_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (attr.sel[1]),
    .acc     (acc),
    .opd     (opd),
    .acc_nxt (acc_nxt)
  );
  // The product is negated as a whole so MULH* see the correct high half.
  always_comb begin
    prod = neg ? -acc : acc;
    quo = acc[XLEN-1:0];
    rem = acc[2*XLEN-1:XLEN];
    res_fix = spec ? spec_val
            : attr.sel == SEL_LO ? prod[XLEN-1:0]
            : attr.sel == SEL_HI ? prod[2*XLEN-1:XLEN]
            : attr.sel == SEL_QUO ? (neg ? -quo : quo)
            : (neg ? -rem : rem);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      attr <= '0;
      tag <= '0;
      neg <= 1'b0;
      spec <= 1'b0;
      spec_val <= '0;
      result_o <= '0;
      tag_o <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
      busy_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          attr <= attr_n;
          tag <= tag_i;
          neg <= neg_n;
          spec <= spec_n;
          spec_val <= spec_val_n;
          opd <= op_i[2] ? b_mag : a_mag;
          acc <= {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
          cnt <= CW'(XLEN);
          ready_o <= 1'b0;
          busy_o <= 1'b1;
          if (EARLY && spec_n) begin
            state <= DONE;
            result_o <= spec_val_n;
            tag_o <= tag_i;
            valid_o <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          result_o <= res_fix;
          tag_o <= tag;
          valid_o <= 1'b1;
          state <= DONE;
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          busy_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
